// File: rtl/background_pixel_pipe.sv
// Three-stage background pixel pipeline: address generation, ROM return alignment, palette lookup.
// Optional horizontal scrolling is compiled in when BG_SCROLL_EN is defined.
module background_pixel_pipe #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        frame_start,
  input  logic [2:0]  scroll_step,
  output logic [18:0] rom_addr,
  input  logic [3:0]  rom_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [23:0] pal_rgb,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        out_blank
);

  logic [9:0]  scroll_x;
  logic [10:0] col_sum;
  logic [9:0]  col;
  logic        pixel_in;
  logic [18:0] next_addr;
  logic        valid1, blank1, valid2, blank2;
  logic [23:0] palette [16];

`ifdef BG_SCROLL_EN
  logic [10:0] scroll_sum;
  assign scroll_sum = {1'b0, scroll_x} + {8'b0, scroll_step};

  // Scroll offset advances once per frame and wraps with a true modulo.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      scroll_x <= '0;
    else if (frame_start)
      scroll_x <= (scroll_sum >= 11'(H_RES)) ? 10'(scroll_sum - 11'(H_RES)) : scroll_sum[9:0];
  end
`else
  logic unused_scroll;
  assign unused_scroll = ^{frame_start, scroll_step};
  assign scroll_x = '0;
`endif

  assign pixel_in  = blank && ({1'b0, DrawX} < 11'(H_RES)) && ({1'b0, DrawY} < 11'(V_RES));
  assign col_sum   = {1'b0, DrawX} + {1'b0, scroll_x};
  assign col       = (col_sum >= 11'(H_RES)) ? 10'(col_sum - 11'(H_RES)) : col_sum[9:0];
  assign next_addr = pixel_in ? (19'(DrawY) * 19'(H_RES) + 19'(col)) : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      valid1   <= 1'b0;
      blank1   <= 1'b0;
      valid2   <= 1'b0;
      blank2   <= 1'b0;
    end else begin
      rom_addr <= next_addr;
      valid1   <= pixel_in;
      blank1   <= blank;
      valid2   <= valid1;
      blank2   <= blank1;
    end
  end

  // A write and a lookup on the same edge see the old entry, since both sample pre-edge state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++)
        palette[i] <= {3{8'(i * 17)}};
    end else if (pal_we) begin
      palette[pal_idx] <= pal_rgb;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {Red, Green, Blue} <= 24'h000000;
      out_blank          <= 1'b0;
    end else begin
      {Red, Green, Blue} <= valid2 ? palette[rom_data] : 24'h000000;
      out_blank          <= blank2;
    end
  end

endmodule

// File: tb/tb_background_pixel_pipe.sv
// Randomised self-checking bench for background_pixel_pipe with a queue-based reference model.
// Scroll expectations follow BG_SCROLL_EN, the same macro that configures the design.
module tb_background_pixel_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  draw_x, draw_y;
  logic        blank, frame_start;
  logic [2:0]  scroll_step;
  logic [18:0] rom_addr;
  logic [3:0]  rom_data;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [23:0] pal_rgb;
  logic [7:0]  red, green, blue;
  logic        out_blank;

  int          total = 0;
  int          bad = 0;
  int          rom_mode = -1;
  logic [23:0] pal_m [16];
  int          scroll_m;
  int          q_addr [$];
  bit          q_valid [$];
  bit          q_blank [$];
  int          exp_addr;
  logic [23:0] exp_rgb;
  logic        exp_ob;

  background_pixel_pipe dut (
    .Clk(clk), .Reset(reset), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .frame_start(frame_start), .scroll_step(scroll_step), .rom_addr(rom_addr),
    .rom_data(rom_data), .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .Red(red), .Green(green), .Blue(blue), .out_blank(out_blank)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_value(input logic [18:0] a);
    if (rom_mode >= 0) return 4'(rom_mode);
    return a[3:0] ^ a[9:6] ^ a[18:15];
  endfunction

  always @(posedge clk) rom_data <= rom_value(rom_addr);

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pal_m[i] = {3{8'(i * 17)}};
    scroll_m = 0;
    q_addr.delete();
    q_valid.delete();
    q_blank.delete();
  endtask

  task automatic drive(input int x, input int y, input logic b);
    draw_x = 10'(x);
    draw_y = 10'(y);
    blank  = b;
  endtask

  // One clock: predict this edge's results from the current inputs, then advance.
  task automatic tick();
    bit v;
    int a, n;
    v = blank && (draw_x < 640) && (draw_y < 480);
    a = v ? (int'(draw_y) * 640 + (int'(draw_x) + scroll_m) % 640) : 0;
    q_addr.push_back(a);
    q_valid.push_back(v);
    q_blank.push_back(blank);
    n = q_addr.size();
    if (n >= 3) begin
      exp_rgb = q_valid[n-3] ? pal_m[rom_value(19'(q_addr[n-3]))] : 24'h000000;
      exp_ob  = q_blank[n-3];
    end else begin
      exp_rgb = 24'h000000;
      exp_ob  = 1'b0;
    end
    if (pal_we) pal_m[pal_idx] = pal_rgb;
`ifdef BG_SCROLL_EN
    if (frame_start) scroll_m = (scroll_m + int'(scroll_step)) % 640;
`endif
    while (q_addr.size() > 3) begin
      void'(q_addr.pop_front());
      void'(q_valid.pop_front());
      void'(q_blank.pop_front());
    end
    exp_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    drive(0, 0, 1'b0);
    pal_we = 1'b0;
    frame_start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (rom_addr !== 19'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0d want=0", rom_addr); end
    total++;
    if ({red, green, blue} !== 24'h000000) begin bad++; $display("[TB] FAIL reset_rgb got=%h want=000000", {red, green, blue}); end
    total++;
    if (out_blank !== 1'b0) begin bad++; $display("[TB] FAIL reset_blank got=%b want=0", out_blank); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_lookup();
    rom_mode = 15;
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, c == 0);
      tick();
      total++;
      if (rom_addr !== 19'(exp_addr)) begin bad++; $display("[TB] FAIL basic_addr got=%0d want=%0d", rom_addr, exp_addr); end
      total++;
      if ({red, green, blue} !== exp_rgb) begin bad++; $display("[TB] FAIL basic_rgb got=%h want=%h", {red, green, blue}, exp_rgb); end
      total++;
      if (out_blank !== exp_ob) begin bad++; $display("[TB] FAIL basic_blank got=%b want=%b", out_blank, exp_ob); end
      if (c == 0) begin
        total++;
        if (rom_addr !== 19'd0) begin bad++; $display("[TB] FAIL basic_addr_c1 got=%0d want=0", rom_addr); end
      end
    end
    total++;
    if ({red, green, blue} !== 24'hFFFFFF) begin bad++; $display("[TB] FAIL basic_rgb_c3 got=%h want=FFFFFF", {red, green, blue}); end
    flush();
  endtask

  task automatic test_bounds();
    int xs [4] = '{639, 700, 0, 5};
    int ys [4] = '{479, 10, 500, 5};
    logic bs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    rom_mode = -1;
    for (int c = 0; c < 4; c++) begin
      drive(xs[c], ys[c], bs[c]);
      tick();
      total++;
      if (rom_addr !== 19'(exp_addr)) begin bad++; $display("[TB] FAIL bounds_addr got=%0d want=%0d", rom_addr, exp_addr); end
      total++;
      if ({red, green, blue} !== exp_rgb) begin bad++; $display("[TB] FAIL bounds_rgb got=%h want=%h", {red, green, blue}, exp_rgb); end
      total++;
      if (out_blank !== exp_ob) begin bad++; $display("[TB] FAIL bounds_blank got=%b want=%b", out_blank, exp_ob); end
      if (c == 0) begin
        total++;
        if (rom_addr !== 19'd307199) begin bad++; $display("[TB] FAIL bounds_max got=%0d want=307199", rom_addr); end
      end
      if (c == 1) begin
        total++;
        if (rom_addr !== 19'd0) begin bad++; $display("[TB] FAIL bounds_offscreen got=%0d want=0", rom_addr); end
      end
    end
    total++;
    if ({red, green, blue} !== 24'h000000 || out_blank !== 1'b1) begin
      bad++; $display("[TB] FAIL bounds_black got=%h/%b want=000000/1", {red, green, blue}, out_blank);
    end
    flush();
  endtask

  task automatic test_palette_collision();
    rom_mode = 3;
    for (int c = 0; c < 4; c++) begin
      drive(c + 1, 1, c < 2);
      pal_we  = (c == 2);
      pal_idx = 4'd3;
      pal_rgb = 24'h12AB34;
      tick();
      total++;
      if (rom_addr !== 19'(exp_addr)) begin bad++; $display("[TB] FAIL coll_addr got=%0d want=%0d", rom_addr, exp_addr); end
      total++;
      if ({red, green, blue} !== exp_rgb) begin bad++; $display("[TB] FAIL coll_rgb got=%h want=%h", {red, green, blue}, exp_rgb); end
      if (c == 2) begin
        total++;
        if ({red, green, blue} !== 24'h333333) begin bad++; $display("[TB] FAIL coll_old got=%h want=333333", {red, green, blue}); end
      end
      if (c == 3) begin
        total++;
        if ({red, green, blue} !== 24'h12AB34) begin bad++; $display("[TB] FAIL coll_new got=%h want=12AB34", {red, green, blue}); end
      end
    end
    pal_we = 1'b0;
    flush();
  endtask

  task automatic test_scroll();
    drive(0, 0, 1'b0);
`ifdef BG_SCROLL_EN
    scroll_step = 3'd5;
    frame_start = 1'b1;
    for (int p = 0; p < 128; p++) begin
      tick();
      total++;
      if (rom_addr !== 19'(exp_addr)) begin bad++; $display("[TB] FAIL scroll_pulse_addr got=%0d want=%0d", rom_addr, exp_addr); end
    end
    frame_start = 1'b0;
    drive(0, 0, 1'b1);
    tick();
    total++;
    if (rom_addr !== 19'd0) begin bad++; $display("[TB] FAIL scroll_wrap0 got=%0d want=0", rom_addr); end
    drive(637, 0, 1'b1);
    frame_start = 1'b1;
    tick();
    total++;
    if (rom_addr !== 19'd637) begin bad++; $display("[TB] FAIL scroll_same_cycle got=%0d want=637", rom_addr); end
    frame_start = 1'b0;
    tick();
    total++;
    if (rom_addr !== 19'd2) begin bad++; $display("[TB] FAIL scroll_step5 got=%0d want=2", rom_addr); end
`else
    scroll_step = 3'd7;
    for (int p = 0; p < 20; p++) begin
      frame_start = p[0];
      drive(10, 1, 1'b1);
      tick();
      total++;
      if (rom_addr !== 19'd650) begin bad++; $display("[TB] FAIL noscroll_addr got=%0d want=650", rom_addr); end
    end
    frame_start = 1'b0;
`endif
    flush();
  endtask

  task automatic test_random();
    rom_mode = -1;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 719), $urandom_range(0, 519), $urandom_range(0, 3) != 0);
      pal_we      = ($urandom_range(0, 7) == 0);
      pal_idx     = 4'($urandom);
      pal_rgb     = 24'($urandom);
      frame_start = ($urandom_range(0, 15) == 0);
      scroll_step = 3'($urandom);
      tick();
      total++;
      if (rom_addr !== 19'(exp_addr)) begin bad++; $display("[TB] FAIL rand_addr c=%0d got=%0d want=%0d", c, rom_addr, exp_addr); end
      total++;
      if ({red, green, blue} !== exp_rgb) begin bad++; $display("[TB] FAIL rand_rgb c=%0d got=%h want=%h", c, {red, green, blue}, exp_rgb); end
      total++;
      if (out_blank !== exp_ob) begin bad++; $display("[TB] FAIL rand_blank c=%0d got=%b want=%b", c, out_blank, exp_ob); end
    end
    flush();
  endtask

  task automatic test_reset_in_flight();
    rom_mode = 3;
    pal_we = 1'b1;
    pal_idx = 4'd3;
    pal_rgb = 24'hABCDEF;
    tick();
    pal_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(c + 20, 7, 1'b1);
      tick();
      total++;
      if (rom_addr !== 19'(exp_addr)) begin bad++; $display("[TB] FAIL flight_addr got=%0d want=%0d", rom_addr, exp_addr); end
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (rom_addr !== 19'd0 || {red, green, blue} !== 24'h000000 || out_blank !== 1'b0) begin
      bad++; $display("[TB] FAIL flight_async got=%0d/%h/%b want=0/000000/0", rom_addr, {red, green, blue}, out_blank);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      drive(4, 4, c == 0);
      tick();
      total++;
      if ({red, green, blue} !== exp_rgb) begin bad++; $display("[TB] FAIL flight_rgb got=%h want=%h", {red, green, blue}, exp_rgb); end
      total++;
      if (out_blank !== exp_ob) begin bad++; $display("[TB] FAIL flight_blank got=%b want=%b", out_blank, exp_ob); end
    end
    total++;
    if ({red, green, blue} !== 24'h333333) begin bad++; $display("[TB] FAIL flight_pal3 got=%h want=333333", {red, green, blue}); end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 1'b0);
    frame_start = 1'b0;
    scroll_step = 3'd0;
    pal_we = 1'b0;
    pal_idx = 4'd0;
    pal_rgb = 24'h0;
    model_reset();
    test_reset();
    test_basic_lookup();
    test_bounds();
    test_palette_collision();
    test_scroll();
    test_random();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
